// File: rtl/unidad_control.sv
// Multi-cycle control unit: IDLE/FETCH/DECODE/EXEC/MEM sequencer for an
// 8-bit accumulator-style datapath with a bounded data-memory wait.
`timescale 1ns/1ps
module unidad_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Instruction,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PC_Enable,
  output logic       PC_Load,
  output logic       IR_Enable,
  output logic       RegA_Enable,
  output logic       RegB_Enable,
  output logic       Data_Sel,
  output logic [1:0] ALU_Op,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       Halted,
  output logic       Illegal,
  output logic       Timeout_Err,
  output logic [2:0] State
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic [2:0] r_state;
  logic [3:0] r_opcode;
  logic       r_reg_sel;
  logic [7:0] r_count;
  logic [2:0] w_next;
  logic [1:0] w_alu_op;
  logic       w_is_ld;
  logic       w_timeout;
  logic       w_unused_bits;

  // Only opcode and register select are architectural; the low bits are don't-care.
  assign w_unused_bits = ^Instruction[2:0];
  assign w_is_ld       = (r_opcode == OP_LD);
  assign w_timeout     = (r_count >= LP_TIMEOUT);
  assign State         = r_state;

  always_comb begin
    w_alu_op = 2'b00;
    case (r_opcode)
      OP_ADD:  w_alu_op = 2'b00;
      OP_SUB:  w_alu_op = 2'b01;
      OP_AND:  w_alu_op = 2'b10;
      OP_OR:   w_alu_op = 2'b11;
      default: w_alu_op = 2'b00;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    PC_Enable   = 1'b0;
    PC_Load     = 1'b0;
    IR_Enable   = 1'b0;
    RegA_Enable = 1'b0;
    RegB_Enable = 1'b0;
    Data_Sel    = 1'b0;
    ALU_Op      = 2'b00;
    Mem_Read    = 1'b0;
    Mem_Write   = 1'b0;
    Halted      = 1'b0;
    Illegal     = 1'b0;
    Timeout_Err = 1'b0;
    case (r_state)
      S_IDLE: begin
        Halted = 1'b1;
        if (Start) w_next = S_FETCH;
      end
      S_FETCH: begin
        IR_Enable = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        case (r_opcode)
          OP_NOP: begin
            PC_Enable = 1'b1;
            w_next    = S_FETCH;
          end
          OP_LD, OP_ST:                  w_next = S_MEM;
          OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_EXEC;
          OP_JMP: begin
            PC_Load = 1'b1;
            w_next  = S_FETCH;
          end
          OP_JZ: begin
            PC_Load   = Zero;
            PC_Enable = ~Zero;
            w_next    = S_FETCH;
          end
          OP_HLT: begin
            PC_Enable = 1'b1;
            w_next    = S_IDLE;
          end
          default: begin
            Illegal   = 1'b1;
            PC_Enable = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        ALU_Op      = w_alu_op;
        RegA_Enable = ~r_reg_sel;
        RegB_Enable = r_reg_sel;
        PC_Enable   = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEM: begin
        // Timeout wins over a late Mem_Ready: the access is abandoned, PC untouched.
        if (w_timeout) begin
          Timeout_Err = 1'b1;
          w_next      = S_IDLE;
        end else begin
          Mem_Read  = w_is_ld;
          Mem_Write = ~w_is_ld;
          if (Mem_Ready) begin
            PC_Enable   = 1'b1;
            Data_Sel    = w_is_ld;
            RegA_Enable = w_is_ld & ~r_reg_sel;
            RegB_Enable = w_is_ld & r_reg_sel;
            w_next      = S_FETCH;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_opcode  <= 4'd0;
      r_reg_sel <= 1'b0;
      r_count   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_opcode  <= Instruction[7:4];
        r_reg_sel <= Instruction[3];
      end
      // Counts completed MEM wait cycles; cleared whenever MEM is left or not yet entered.
      r_count <= ((r_state == S_MEM) && (w_next == S_MEM)) ? r_count + 8'd1 : 8'd0;
    end
  end

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control (TIMEOUT=4): cycle-by-cycle output vectors
// compared against hand-built expectations.
`timescale 1ns/1ps
module tb_unidad_control;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Instruction = 8'h00;
  logic       Zero = 1'b0;
  logic       Mem_Ready = 1'b0;
  logic       PC_Enable, PC_Load, IR_Enable, RegA_Enable, RegB_Enable, Data_Sel;
  logic [1:0] ALU_Op;
  logic       Mem_Read, Mem_Write, Halted, Illegal, Timeout_Err;
  logic [2:0] State;
  logic [15:0] w_obs;

  int n_checks = 0;
  int n_fail   = 0;

  unidad_control #(.TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .Zero(Zero), .Mem_Ready(Mem_Ready), .PC_Enable(PC_Enable), .PC_Load(PC_Load),
    .IR_Enable(IR_Enable), .RegA_Enable(RegA_Enable), .RegB_Enable(RegB_Enable),
    .Data_Sel(Data_Sel), .ALU_Op(ALU_Op), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Halted(Halted), .Illegal(Illegal), .Timeout_Err(Timeout_Err), .State(State)
  );

  always #5 Clock = ~Clock;

  assign w_obs = {PC_Enable, PC_Load, IR_Enable, RegA_Enable, RegB_Enable, Data_Sel,
                  ALU_Op, Mem_Read, Mem_Write, Halted, Illegal, Timeout_Err, State};

  // Expected vector builder, same field order as w_obs.
  function automatic logic [15:0] mk(input logic [2:0] st, input logic h, pce, pcl, ire,
                                     ra, rb, ds, input logic [1:0] alu,
                                     input logic mr, mw, ill, to);
    return {pce, pcl, ire, ra, rb, ds, alu, mr, mw, h, ill, to, st};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, leave time for inputs to be driven before sampling.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic look(input string tag, input logic [15:0] exp);
    #1;
    check(tag, w_obs, exp);
  endtask

  // Mutual-exclusion invariants, sampled mid-cycle every cycle.
  always @(negedge Clock) begin
    check("pc_excl", {14'd0, PC_Enable, PC_Load} & {14'd0, PC_Load, PC_Enable}, 16'd0);
    check("reg_excl", {15'd0, RegA_Enable & RegB_Enable}, 16'd0);
  end

  logic [15:0] v_idle, v_fetch, v_dec0;
  logic [7:0]  t_instr[5];
  logic [15:0] t_dec[5];
  logic        t_alu[5];
  logic [15:0] t_exec[5];

  initial begin
    v_idle  = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    v_fetch = mk(3'd1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    v_dec0  = mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    tick(); tick();
    Reset = 1'b0;
    look("reset_idle", v_idle);

    // ADD A
    Instruction = 8'h30; Start = 1'b1;
    look("idle_start_hi", v_idle);
    tick(); Start = 1'b0;
    look("add_fetch", v_fetch);
    tick(); look("add_decode", v_dec0);
    tick(); look("add_exec", mk(3'd3, 0, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); Instruction = 8'h18;
    look("add_refetch", v_fetch);

    // LD B, three wait cycles
    tick(); look("ld_decode", v_dec0);
    tick(); look("ld_wait0", mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
    tick(); look("ld_wait1", mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
    tick(); look("ld_wait2", mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
    tick(); Mem_Ready = 1'b1;
    look("ld_done", mk(3'd4, 0, 1, 0, 0, 0, 1, 1, 2'b00, 1, 0, 0, 0));
    tick(); Instruction = 8'h60; Zero = 1'b1;
    look("fetch_ready_ignored", v_fetch);
    Mem_Ready = 1'b0;

    // JZ taken then not taken
    tick(); look("jz_taken", mk(3'd2, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); Zero = 1'b0;
    look("jz_fetch2", v_fetch);
    tick(); look("jz_not_taken", mk(3'd2, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); Instruction = 8'h20;
    look("st_fetch", v_fetch);

    // ST with Mem_Ready stuck low -> timeout after 4 strobe cycles
    tick(); look("st_decode", v_dec0);
    for (int i = 0; i < 4; i++) begin
      tick(); look($sformatf("st_strobe%0d", i), mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
    end
    tick(); look("st_timeout", mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    tick(); look("st_to_idle", v_idle);

    // Illegal opcode, then HLT with Start held high until IDLE
    Instruction = 8'hF0; Start = 1'b1;
    tick(); Start = 1'b0;
    look("ill_fetch", v_fetch);
    tick(); look("ill_decode", mk(3'd2, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    tick(); Instruction = 8'h70; Start = 1'b1;
    look("hlt_fetch", v_fetch);
    tick(); look("hlt_decode", mk(3'd2, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); Start = 1'b0;
    look("hlt_idle", v_idle);
    tick(); look("hlt_stays_idle", v_idle);

    // Reset during MEM (LD A)
    Instruction = 8'h10; Start = 1'b1;
    tick(); Start = 1'b0;
    tick(); look("rst_ld_decode", v_dec0);
    tick(); Reset = 1'b1;
    look("rst_mem_before", mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
    tick(); Reset = 1'b0;
    look("rst_mem_after", v_idle);
    tick(); look("rst_mem_idle", v_idle);

    // Remaining decode paths: NOP, JMP, SUB B, AND A, OR B
    t_instr[0] = 8'h00; t_alu[0] = 0;
    t_dec[0] = mk(3'd2, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); t_exec[0] = 16'd0;
    t_instr[1] = 8'h50; t_alu[1] = 0;
    t_dec[1] = mk(3'd2, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); t_exec[1] = 16'd0;
    t_instr[2] = 8'h48; t_alu[2] = 1; t_dec[2] = v_dec0;
    t_exec[2] = mk(3'd3, 0, 1, 0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0);
    t_instr[3] = 8'h80; t_alu[3] = 1; t_dec[3] = v_dec0;
    t_exec[3] = mk(3'd3, 0, 1, 0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0);
    t_instr[4] = 8'h98; t_alu[4] = 1; t_dec[4] = v_dec0;
    t_exec[4] = mk(3'd3, 0, 1, 0, 0, 0, 1, 0, 2'b11, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      Instruction = t_instr[k]; Start = 1'b1;
      tick(); Start = 1'b0;
      look($sformatf("tbl%0d_fetch", k), v_fetch);
      tick(); look($sformatf("tbl%0d_decode", k), t_dec[k]);
      if (t_alu[k]) begin
        tick(); look($sformatf("tbl%0d_exec", k), t_exec[k]);
      end
      tick(); look($sformatf("tbl%0d_next", k), v_fetch);
      Reset = 1'b1;
      tick(); Reset = 1'b0;
      look($sformatf("tbl%0d_reset", k), v_idle);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
